ct_rtu_ptr_ctrl_64: RTL and testbench
=====================================

Name: ct_rtu_ptr_ctrl_64

Overview:
- Pointer/occupancy controller for a 64-entry circular retire-side queue, such as a ROB-style entry pool.
- Allocates up to 2 entries per cycle at the create pointer and frees up to 2 entries per cycle at the retire pointer.
- Presents both pointers in binary and as 64-bit one-hot vectors (6-to-64 decode), plus a per-entry valid vector, to the entry array.
- Sits between the IDU create path and the RTU retire logic.

Parameters:
- DEPTH, 64, number of queue entries; fixed at 2^PTR_W.
- PTR_W, 6, pointer width.
- CNT_W, 7, occupancy counter width; must hold 0..DEPTH.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  async active-low reset
- ctrl_create_req  in  2  thermometer create request: 00 = none, 01 = one entry, 11 = two entries; 10 is illegal
- ctrl_create_gnt  out  1  create accepted this cycle
- ctrl_retire_req  in  2  thermometer retire request, same encoding as create
- ctrl_flush  in  1  discard all entries
- create_ptr0  out  6  binary create pointer
- create_ptr0_expand  out  64  one-hot of create_ptr0
- create_ptr1_expand  out  64  one-hot of create_ptr0+1 (mod 64)
- retire_ptr0  out  6  binary retire pointer
- retire_ptr0_expand  out  64  one-hot of retire_ptr0
- retire_ptr1_expand  out  64  one-hot of retire_ptr0+1 (mod 64)
- entry_vld  out  64  per-entry occupied flags
- entry_cnt  out  7  number of occupied entries
- queue_full  out  1  entry_cnt == 64
- queue_empty  out  1  entry_cnt == 0

Behaviour:
- Registered state: create_ptr (6b), retire_ptr (6b), cnt (7b), vld (64b).
- On cpurst_b low, asynchronously: create_ptr = 0, retire_ptr = 0, cnt = 0, vld = 0.
- Outputs at reset: create_ptr0_expand = 0x1, create_ptr1_expand = 0x2, retire_ptr0_expand = 0x1, retire_ptr1_expand = 0x2, entry_vld = 0, entry_cnt = 0, queue_empty = 1, queue_full = 0, ctrl_create_gnt = 0.
- All outputs are combinational from registered state only; no input-to-output path except ctrl_create_gnt.
- Request counts: nc = popcount(ctrl_create_req), nr_req = popcount(ctrl_retire_req).
- Create grant: ctrl_create_gnt = (nc != 0) & !ctrl_flush & (64 - cnt >= nc).
  - All-or-nothing: a 2-entry request with only 1 free entry is not granted.
  - Same-cycle retire does not free space for create; no bypass.
- Retire: accepted count nr = min(nr_req, cnt), using the registered cnt. Retire requests beyond occupancy are silently dropped.
- Next state when not flushing:
  - create_ptr += gnt ? nc : 0 (mod 64)
  - retire_ptr += nr (mod 64)
  - cnt = cnt + (gnt ? nc : 0) - nr
- vld update: set bits at create_ptr and create_ptr+1 per granted count; clear bits at retire_ptr and retire_ptr+1 per nr.
  - Sets and clears never target the same bit in one cycle, because creates hit only free entries and retires hit only occupied ones.
- Flush: ctrl_flush = 1 overrides create and retire in the same cycle. Next cycle both pointers = 0, cnt = 0, vld = 0, and ctrl_create_gnt = 0 during the flush cycle.
- Wrap-around: pointers are modulo 64. ptr+1 from 63 is 0, and a 2-entry create at ptr 63 occupies entries 63 and 0.
- Full/empty: queue_full = 1 blocks every create. Empty with a retire request performs no state change.
- Invariants, asserted in the bench:
  - popcount(entry_vld) == entry_cnt.
  - entry_vld is set exactly on the cnt entries starting at retire_ptr0.
  - (create_ptr - retire_ptr) mod 64 == cnt mod 64.
- Illegal encoding 10 on either request: behaviour undefined; the bench asserts it never occurs.

Test Plan:
- Reset, then 32 cycles of create_req = 11 -> cnt steps by 2 each cycle to 64. queue_full = 1 after cycle 32, create_ptr0 = 0 (wrapped), entry_vld = all ones, gnt = 1 on every cycle.
- Full queue, create_req = 01 and retire_req = 11 in the same cycle -> gnt = 0, cnt = 62, retire_ptr0 = 2, entry_vld[1:0] = 0.
- cnt = 63, create_ptr0 = 63, create_req = 11 -> gnt = 0. Next cycle with create_req = 01 -> gnt = 1, create_ptr0 = 0, cnt = 64.
- Pointers at 62, cnt = 0, create 11 then retire 11 -> entries 62 and 63 valid after cycle 1. After the retire, retire_ptr0 = 0, retire_ptr0_expand = 0x1, queue_empty = 1.
- cnt = 1, retire_req = 11 -> only 1 entry retired: cnt = 0, retire_ptr advances by 1.
- cnt = 10, flush asserted with create_req = 11 and retire_req = 11 -> gnt = 0. Next cycle: pointers = 0, cnt = 0, entry_vld = 0.
- Async reset asserted mid-stream (cnt = 20) -> immediately pointers = 0, cnt = 0, expands = 0x1 / 0x2.

Source files
------------

// File: rtl/ct_rtu_ptr_ctrl_64.sv
// Pointer and occupancy controller for a 64-entry circular retire-side queue.
// Allocates up to two entries per cycle at the create pointer and frees up to two at the retire pointer.
module ct_rtu_ptr_ctrl_64 #(
    parameter int PTR_W = 6,
    parameter int DEPTH = 1 << PTR_W,
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic [1:0]       ctrl_create_req,
    output logic             ctrl_create_gnt,
    input  logic [1:0]       ctrl_retire_req,
    input  logic             ctrl_flush,
    output logic [PTR_W-1:0] create_ptr0,
    output logic [DEPTH-1:0] create_ptr0_expand,
    output logic [DEPTH-1:0] create_ptr1_expand,
    output logic [PTR_W-1:0] retire_ptr0,
    output logic [DEPTH-1:0] retire_ptr0_expand,
    output logic [DEPTH-1:0] retire_ptr1_expand,
    output logic [DEPTH-1:0] entry_vld,
    output logic [CNT_W-1:0] entry_cnt,
    output logic             queue_full,
    output logic             queue_empty
);

    logic [PTR_W-1:0] create_ptr;
    logic [PTR_W-1:0] retire_ptr;
    logic [CNT_W-1:0] cnt;
    logic [DEPTH-1:0] vld;

    logic [1:0]       nc;
    logic [1:0]       nr_req;
    logic [1:0]       nr;
    logic [1:0]       n_add;
    logic [CNT_W-1:0] free_cnt;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] vld_nxt;

    function automatic logic [DEPTH-1:0] expand(input logic [PTR_W-1:0] p);
        return {{(DEPTH-1){1'b0}}, 1'b1} << p;
    endfunction

    // Thermometer requests: the popcount is the number of entries asked for.
    assign nc       = {1'b0, ctrl_create_req[1]} + {1'b0, ctrl_create_req[0]};
    assign nr_req   = {1'b0, ctrl_retire_req[1]} + {1'b0, ctrl_retire_req[0]};
    assign free_cnt = CNT_W'(DEPTH) - cnt;

    // All-or-nothing grant against the registered free count; same-cycle retires do not help.
    assign ctrl_create_gnt = (nc != 2'd0) && !ctrl_flush && (free_cnt >= CNT_W'(nc));
    assign n_add           = ctrl_create_gnt ? nc : 2'd0;
    assign nr              = (CNT_W'(nr_req) > cnt) ? cnt[1:0] : nr_req;

    assign create_ptr0        = create_ptr;
    assign retire_ptr0        = retire_ptr;
    assign create_ptr0_expand = expand(create_ptr);
    assign create_ptr1_expand = expand(create_ptr + PTR_W'(1));
    assign retire_ptr0_expand = expand(retire_ptr);
    assign retire_ptr1_expand = expand(retire_ptr + PTR_W'(1));
    assign entry_vld          = vld;
    assign entry_cnt          = cnt;
    assign queue_full         = (cnt == CNT_W'(DEPTH));
    assign queue_empty        = (cnt == '0);

    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (n_add != 2'd0) set_mask = set_mask | create_ptr0_expand;
        if (n_add == 2'd2) set_mask = set_mask | create_ptr1_expand;
        if (nr != 2'd0)    clr_mask = clr_mask | retire_ptr0_expand;
        if (nr == 2'd2)    clr_mask = clr_mask | retire_ptr1_expand;
        // Creates only hit free entries and retires only occupied ones, so the masks never overlap.
        vld_nxt = (vld & ~clr_mask) | set_mask;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            create_ptr <= '0;
            retire_ptr <= '0;
            cnt        <= '0;
            vld        <= '0;
        end else if (ctrl_flush) begin
            create_ptr <= '0;
            retire_ptr <= '0;
            cnt        <= '0;
            vld        <= '0;
        end else begin
            create_ptr <= create_ptr + PTR_W'(n_add);
            retire_ptr <= retire_ptr + PTR_W'(nr);
            cnt        <= cnt + CNT_W'(n_add) - CNT_W'(nr);
            vld        <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_ct_rtu_ptr_ctrl_64.sv
// Self-checking bench for ct_rtu_ptr_ctrl_64: directed scenarios plus random traffic
// compared against a queue-occupancy model built from counts and an entry array.
module tb_ct_rtu_ptr_ctrl_64;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic [1:0]  ctrl_create_req;
    logic        ctrl_create_gnt;
    logic [1:0]  ctrl_retire_req;
    logic        ctrl_flush;
    logic [5:0]  create_ptr0;
    logic [63:0] create_ptr0_expand;
    logic [63:0] create_ptr1_expand;
    logic [5:0]  retire_ptr0;
    logic [63:0] retire_ptr0_expand;
    logic [63:0] retire_ptr1_expand;
    logic [63:0] entry_vld;
    logic [6:0]  entry_cnt;
    logic        queue_full;
    logic        queue_empty;

    ct_rtu_ptr_ctrl_64 dut (
        .forever_cpuclk    (forever_cpuclk),
        .cpurst_b          (cpurst_b),
        .ctrl_create_req   (ctrl_create_req),
        .ctrl_create_gnt   (ctrl_create_gnt),
        .ctrl_retire_req   (ctrl_retire_req),
        .ctrl_flush        (ctrl_flush),
        .create_ptr0       (create_ptr0),
        .create_ptr0_expand(create_ptr0_expand),
        .create_ptr1_expand(create_ptr1_expand),
        .retire_ptr0       (retire_ptr0),
        .retire_ptr0_expand(retire_ptr0_expand),
        .retire_ptr1_expand(retire_ptr1_expand),
        .entry_vld         (entry_vld),
        .entry_cnt         (entry_cnt),
        .queue_full        (queue_full),
        .queue_empty       (queue_empty)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: occupancy count, two pointers and a plain array of entry flags.
    int m_cnt;
    int m_cp;
    int m_rp;
    bit m_vld [64];
    logic got_gnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] onehot(input int p);
        logic [63:0] v;
        v = '0;
        v[p % 64] = 1'b1;
        return v;
    endfunction

    function automatic int pop2(input logic [1:0] r);
        return int'(r[0]) + int'(r[1]);
    endfunction

    function automatic logic [63:0] model_vld();
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = m_vld[i];
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_cp  = 0;
        m_rp  = 0;
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [63:0] inv;
        int pc;
        check({tag, ".create_ptr0"}, 64'(create_ptr0), 64'(m_cp));
        check({tag, ".retire_ptr0"}, 64'(retire_ptr0), 64'(m_rp));
        check({tag, ".cptr0_exp"}, create_ptr0_expand, onehot(m_cp));
        check({tag, ".cptr1_exp"}, create_ptr1_expand, onehot(m_cp + 1));
        check({tag, ".rptr0_exp"}, retire_ptr0_expand, onehot(m_rp));
        check({tag, ".rptr1_exp"}, retire_ptr1_expand, onehot(m_rp + 1));
        check({tag, ".entry_vld"}, entry_vld, model_vld());
        check({tag, ".entry_cnt"}, 64'(entry_cnt), 64'(m_cnt));
        check({tag, ".full"}, 64'(queue_full), 64'(m_cnt == 64));
        check({tag, ".empty"}, 64'(queue_empty), 64'(m_cnt == 0));
        // Invariants across DUT outputs.
        pc = $countones(entry_vld);
        check({tag, ".inv_pop"}, 64'(pc), 64'(entry_cnt));
        inv = '0;
        for (int i = 0; i < int'(entry_cnt); i++) inv[(int'(retire_ptr0) + i) % 64] = 1'b1;
        check({tag, ".inv_span"}, entry_vld, inv);
        check({tag, ".inv_dist"}, 64'((int'(create_ptr0) - int'(retire_ptr0) + 64) % 64),
              64'(int'(entry_cnt) % 64));
    endtask

    // One clock cycle: starts and ends at a falling edge.
    task automatic cycle(input logic [1:0] c, input logic [1:0] r, input logic f, input string tag);
        int nc, nr, nadd;
        bit g;
        assert (c != 2'b10 && r != 2'b10) else $error("illegal request encoding");
        ctrl_create_req = c;
        ctrl_retire_req = r;
        ctrl_flush      = f;
        #1;
        nc = pop2(c);
        g  = (nc != 0) && !f && (64 - m_cnt >= nc);
        got_gnt = ctrl_create_gnt;
        check({tag, ".gnt"}, 64'(ctrl_create_gnt), 64'(g));
        @(posedge forever_cpuclk);
        if (f) begin
            model_reset();
        end else begin
            nadd = g ? nc : 0;
            nr   = (pop2(r) < m_cnt) ? pop2(r) : m_cnt;
            for (int i = 0; i < nr; i++)   m_vld[(m_rp + i) % 64] = 1'b0;
            for (int i = 0; i < nadd; i++) m_vld[(m_cp + i) % 64] = 1'b1;
            m_cp  = (m_cp + nadd) % 64;
            m_rp  = (m_rp + nr) % 64;
            m_cnt = m_cnt + nadd - nr;
        end
        @(negedge forever_cpuclk);
        check_state(tag);
    endtask

    function automatic logic [1:0] rnd_req();
        case ($urandom_range(2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    initial begin
        ctrl_create_req = 2'b00;
        ctrl_retire_req = 2'b00;
        ctrl_flush      = 1'b0;
        cpurst_b        = 1'b0;
        model_reset();
        repeat (2) @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        @(negedge forever_cpuclk);

        // Reset state.
        check_state("reset");
        check("reset.gnt", 64'(ctrl_create_gnt), 64'd0);
        check("reset.cptr1_exp", create_ptr1_expand, 64'h2);

        // Fill with 2 creates per cycle.
        for (int i = 0; i < 32; i++) begin
            cycle(2'b11, 2'b00, 1'b0, "fill");
            check("fill.gnt_one", 64'(got_gnt), 64'd1);
        end
        check("fill.full", 64'(queue_full), 64'd1);
        check("fill.cptr_wrap", 64'(create_ptr0), 64'd0);
        check("fill.vld_all", entry_vld, 64'hFFFF_FFFF_FFFF_FFFF);

        // Full: create blocked, retire two.
        cycle(2'b01, 2'b11, 1'b0, "full_ret");
        check("full_ret.gnt", 64'(got_gnt), 64'd0);
        check("full_ret.cnt", 64'(entry_cnt), 64'd62);
        check("full_ret.rptr", 64'(retire_ptr0), 64'd2);
        check("full_ret.vld_lo", 64'(entry_vld[1:0]), 64'd0);

        // cnt=63 at create_ptr 63: a 2-entry create is refused, a 1-entry one wraps.
        cycle(2'b00, 2'b00, 1'b1, "flush_a");
        for (int i = 0; i < 31; i++) cycle(2'b11, 2'b00, 1'b0, "to63");
        cycle(2'b01, 2'b00, 1'b0, "to63");
        check("c63.cnt", 64'(entry_cnt), 64'd63);
        check("c63.cptr", 64'(create_ptr0), 64'd63);
        cycle(2'b11, 2'b00, 1'b0, "c63_two");
        check("c63_two.gnt", 64'(got_gnt), 64'd0);
        cycle(2'b01, 2'b00, 1'b0, "c63_one");
        check("c63_one.gnt", 64'(got_gnt), 64'd1);
        check("c63_one.cptr", 64'(create_ptr0), 64'd0);
        check("c63_one.cnt", 64'(entry_cnt), 64'd64);

        // Empty at pointer 62: create two across the wrap, then retire them.
        cycle(2'b00, 2'b00, 1'b1, "flush_b");
        for (int i = 0; i < 31; i++) cycle(2'b11, 2'b00, 1'b0, "to62c");
        for (int i = 0; i < 31; i++) cycle(2'b00, 2'b11, 1'b0, "to62r");
        check("p62.rptr", 64'(retire_ptr0), 64'd62);
        check("p62.empty", 64'(queue_empty), 64'd1);
        cycle(2'b11, 2'b00, 1'b0, "p62_c");
        check("p62_c.vld_hi", 64'(entry_vld[63:62]), 64'd3);
        cycle(2'b00, 2'b11, 1'b0, "p62_r");
        check("p62_r.rptr", 64'(retire_ptr0), 64'd0);
        check("p62_r.rexp", retire_ptr0_expand, 64'h1);
        check("p62_r.empty", 64'(queue_empty), 64'd1);

        // Empty with a retire request changes nothing.
        cycle(2'b00, 2'b11, 1'b0, "empty_ret");
        check("empty_ret.rptr", 64'(retire_ptr0), 64'd0);

        // Retire of 2 with only 1 occupied.
        cycle(2'b01, 2'b00, 1'b0, "one");
        cycle(2'b00, 2'b11, 1'b0, "ret_over");
        check("ret_over.cnt", 64'(entry_cnt), 64'd0);
        check("ret_over.rptr", 64'(retire_ptr0), 64'd1);

        // Flush overrides create and retire.
        for (int i = 0; i < 5; i++) cycle(2'b11, 2'b00, 1'b0, "to10");
        check("to10.cnt", 64'(entry_cnt), 64'd10);
        cycle(2'b11, 2'b11, 1'b1, "flush_c");
        check("flush_c.gnt", 64'(got_gnt), 64'd0);
        check("flush_c.cptr", 64'(create_ptr0), 64'd0);
        check("flush_c.rptr", 64'(retire_ptr0), 64'd0);
        check("flush_c.cnt", 64'(entry_cnt), 64'd0);
        check("flush_c.vld", entry_vld, 64'd0);

        // Random traffic, biased so the queue visits both full and empty.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c, r;
            c = rnd_req();
            r = rnd_req();
            if ((i / 200) % 2 == 0 && $urandom_range(3) == 0) r = 2'b00;
            if ((i / 200) % 2 == 1 && $urandom_range(3) == 0) c = 2'b00;
            cycle(c, r, ($urandom_range(150) == 0), "rand");
        end

        // Asynchronous reset in the middle of traffic.
        cycle(2'b00, 2'b00, 1'b1, "flush_d");
        for (int i = 0; i < 10; i++) cycle(2'b11, 2'b00, 1'b0, "to20");
        check("to20.cnt", 64'(entry_cnt), 64'd20);
        #2;
        cpurst_b = 1'b0;
        #1;
        check("arst.cptr", 64'(create_ptr0), 64'd0);
        check("arst.rptr", 64'(retire_ptr0), 64'd0);
        check("arst.cnt", 64'(entry_cnt), 64'd0);
        check("arst.vld", entry_vld, 64'd0);
        check("arst.cexp0", create_ptr0_expand, 64'h1);
        check("arst.cexp1", create_ptr1_expand, 64'h2);
        check("arst.rexp0", retire_ptr0_expand, 64'h1);
        check("arst.rexp1", retire_ptr1_expand, 64'h2);
        model_reset();
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        cycle(2'b11, 2'b00, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
